// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide, one step per cycle.
// Latency: done 32 cycles after accept; divide-by-zero/overflow (and MUL* with MULDIV_FAST_MUL_EN) after 1.
// Backpressure: accepts only when ready (IDLE/DONE); start while busy is dropped, kill aborts in BUSY.
//
// Ports: clk, rst_n (async active-low); start/op/rs1/rs2 request (op = RV32M funct3);
//        kill flushes the in-flight operation; ready/busy/done status; result holds the last answer.
// Build option: define MULDIV_FAST_MUL_EN to compute MUL/MULH/MULHSU/MULHU with a single-cycle
//               32x32 multiplier; divide always uses the iterative path.
module muldiv_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic        kill,
    output logic        ready,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state, state_nx;
    logic [2:0]  op_q;
    logic [31:0] rs1_q, rs2_q;
    logic [31:0] hi_q, lo_q;   // mul: {partial product, multiplier}; div: {remainder, dividend/quotient}
    logic [4:0]  cnt_q;

    logic        accept, finish;

    // rs1 is treated as signed for MULH, MULHSU, DIV, REM
    function automatic logic a_signed(input logic [2:0] f);
        return (f == 3'b001) || (f == 3'b010) || (f == 3'b100) || (f == 3'b110);
    endfunction

    // rs2 is treated as signed for MULH, DIV, REM
    function automatic logic b_signed(input logic [2:0] f);
        return (f == 3'b001) || (f == 3'b100) || (f == 3'b110);
    endfunction

    function automatic logic [31:0] mag(input logic [31:0] x, input logic s);
        return (s && x[31]) ? -x : x;
    endfunction

    // Operations that finish after a single BUSY cycle instead of 32 iterations
    function automatic logic short_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic sp;
        sp = f[2] && ((b == 32'd0) ||
                      (!f[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)));
`ifdef MULDIV_FAST_MUL_EN
        return sp || !f[2];
`else
        return sp;
`endif
    endfunction

    // ---------------- control ----------------
    assign ready  = (state != BUSY);
    assign busy   = (state == BUSY);
    assign done   = (state == DONE);
    assign accept = start && ready && !kill;
    assign finish = (state == BUSY) && !kill && (cnt_q == 5'd31);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept) state_nx = BUSY;
            BUSY: begin
                if (kill)                   state_nx = IDLE;
                else if (cnt_q == 5'd31)    state_nx = DONE;
            end
            DONE:    state_nx = accept ? BUSY : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // ---------------- datapath ----------------
    logic        sa, sb, neg_ab;
    logic [31:0] mag_a, mag_b, opnd;
    logic [32:0] sum33, shifted;
    logic        ge;
    logic [31:0] diff32;
    logic [31:0] hi_st, lo_st;
    logic [63:0] prod_mag, prod;
    logic [31:0] quo, rem, res_final;
    logic        sp_zero, sp_ovf;

    assign sa     = a_signed(op_q) && rs1_q[31];
    assign sb     = b_signed(op_q) && rs2_q[31];
    assign neg_ab = sa ^ sb;
    assign mag_a  = mag(rs1_q, a_signed(op_q));
    assign mag_b  = mag(rs2_q, b_signed(op_q));
    assign opnd   = op_q[2] ? mag_b : mag_a;   // divisor, or multiplicand

    // multiply step: add multiplicand when multiplier LSB is set, then shift right
    assign sum33   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd} : 33'd0);
    // divide step: shift next dividend bit into remainder, subtract divisor if it fits
    assign shifted = {hi_q, lo_q[31]};
    assign ge      = (shifted >= {1'b0, opnd});
    assign diff32  = shifted[31:0] - opnd;

    always_comb begin
        hi_st = {sum33[32:1]};
        lo_st = {sum33[0], lo_q[31:1]};
        if (op_q[2]) begin
            hi_st = ge ? diff32 : shifted[31:0];
            lo_st = {lo_q[30:0], ge};
        end
    end

`ifdef MULDIV_FAST_MUL_EN
    assign prod_mag = {32'd0, mag_a} * {32'd0, mag_b};
`else
    assign prod_mag = {hi_st, lo_st};
`endif
    assign prod = neg_ab ? -prod_mag : prod_mag;
    assign quo  = neg_ab ? -lo_st : lo_st;
    assign rem  = sa ? -hi_st : hi_st;   // remainder follows the dividend's sign

    assign sp_zero = op_q[2] && (rs2_q == 32'd0);
    assign sp_ovf  = op_q[2] && !op_q[0] && (rs1_q == 32'h8000_0000) && (rs2_q == 32'hFFFF_FFFF);

    always_comb begin
        res_final = 32'd0;
        if (sp_zero)      res_final = op_q[1] ? rs1_q : 32'hFFFF_FFFF;
        else if (sp_ovf)  res_final = op_q[1] ? 32'd0 : 32'h8000_0000;
        else if (op_q[2]) res_final = op_q[1] ? rem : quo;
        else              res_final = (op_q[1:0] == 2'b00) ? prod[31:0] : prod[63:32];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q   <= 3'd0;
            rs1_q  <= 32'd0;
            rs2_q  <= 32'd0;
            hi_q   <= 32'd0;
            lo_q   <= 32'd0;
            cnt_q  <= 5'd0;
            result <= 32'd0;
        end else begin
            if (accept) begin
                op_q  <= op;
                rs1_q <= rs1;
                rs2_q <= rs2;
                hi_q  <= 32'd0;
                lo_q  <= op[2] ? mag(rs1, a_signed(op)) : mag(rs2, b_signed(op));
                // short operations jump straight to the last count so they finish next edge
                cnt_q <= short_op(op, rs1, rs2) ? 5'd31 : 5'd0;
            end else if ((state == BUSY) && !kill) begin
                hi_q  <= hi_st;
                lo_q  <= lo_st;
                cnt_q <= cnt_q + 5'd1;
            end
            if (finish) result <= res_final;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] rs1 = 32'd0;
    logic [31:0] rs2 = 32'd0;
    logic        kill = 1'b0;
    logic        ready, busy, done;
    logic [31:0] result;

    int checks = 0;
    int failures = 0;
    logic [31:0] last_res = 32'd0;

    muldiv_unit dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .rs1    (rs1),
        .rs2    (rs2),
        .kill   (kill),
        .ready  (ready),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic following the RV32M rules
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        longint ub;
        longint p;
        logic [63:0] up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'd0, b});
        case (f)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin up = {32'd0, a} * {32'd0, b}; return up[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = sa / sb; return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f >= 3'd4 && b == 0) return 1;
        if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MULDIV_FAST_MUL_EN
        if (f < 3'd4) return 1;
`endif
        return 32;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return $urandom_range(0, 15);
            default: return $urandom;
        endcase
    endfunction

    // Called just after a rising edge; the request is accepted at the next edge (edge 0).
    // Afterwards inputs are scrambled so the unit must rely on its latched copy.
    task automatic start_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; op = f; rs1 = a; rs2 = b;
        @(posedge clk); #1;
        start = 1'b0; op = 3'($urandom_range(0, 7)); rs1 = $urandom; rs2 = $urandom;
    endtask

    // Counts edges until done is seen; n = 60 means it never came.
    task automatic wait_done(input int n0, output int n, output logic stable);
        logic [31:0] prev;
        prev = result;
        stable = 1'b1;
        n = n0;
        while (n < 60) begin
            @(posedge clk); #1;
            n++;
            if (done) break;
            if (result !== prev) stable = 1'b0;
        end
    endtask

    task automatic do_op(input string tag, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] e;
        int n;
        logic st;
        e = model(f, a, b);
        start_op(f, a, b);
        wait_done(0, n, st);
        chk({tag, "_lat"}, 32'(n), 32'(exp_lat(f, a, b)));
        chk({tag, "_res"}, result, e);
        chk({tag, "_hold"}, {31'd0, st}, 32'd1);
        @(posedge clk); #1;
        chk({tag, "_pulse"}, {31'd0, done}, 32'd0);
        last_res = e;
    endtask

    initial begin
        int n;
        logic st;
        logic saw;

        // reset values
        #1;
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_result", result, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // directed scenarios
        do_op("mul_7x6", 3'd0, 32'd7, 32'd6);
        chk("mul_7x6_val", last_res, 32'h0000_002A);
        do_op("mulh_m1", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_op("mulhu_m1", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_op("mulhsu", 3'd2, 32'hFFFF_FFFE, 32'h8000_0001);
        do_op("div_m7", 3'd4, 32'hFFFF_FFF9, 32'd2);
        chk("div_m7_val", result, 32'hFFFF_FFFD);
        do_op("rem_m7", 3'd6, 32'hFFFF_FFF9, 32'd2);
        chk("rem_m7_val", result, 32'hFFFF_FFFF);
        do_op("divu_z", 3'd5, 32'd1234, 32'd0);
        do_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op("rem_z", 3'd6, 32'hDEAD_BEEF, 32'd0);
        do_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op("remu_big", 3'd7, 32'hFFFF_FFFF, 32'h8000_0001);

        // kill mid-divide: no done, result untouched, FSM idle the following edge
        start_op(3'd4, 32'd1000, 32'd3);
        saw = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (done) saw = 1'b1;
        end
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        chk("kill_ready", {31'd0, ready}, 32'd1);
        chk("kill_busy", {31'd0, busy}, 32'd0);
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done) saw = 1'b1;
        end
        chk("kill_nodone", {31'd0, saw}, 32'd0);
        chk("kill_result", result, last_res);
        do_op("after_kill", 3'd5, 32'd1000, 32'd3);

        // kill in IDLE blocks a simultaneous request
        start = 1'b1; kill = 1'b1; op = 3'd4; rs1 = 32'd9; rs2 = 32'd2;
        @(posedge clk); #1;
        start = 1'b0; kill = 1'b0;
        chk("idle_kill_busy", {31'd0, busy}, 32'd0);
        chk("idle_kill_res", result, last_res);

        // start while busy is ignored
        start_op(3'd4, 32'd1000, 32'd7);
        for (int k = 0; k < 20; k++) begin
            start = 1'b1; op = 3'($urandom_range(0, 7)); rs1 = $urandom; rs2 = $urandom;
            @(posedge clk); #1;
        end
        start = 1'b0;
        wait_done(20, n, st);
        chk("ign_lat", 32'(n), 32'd32);
        chk("ign_res", result, 32'd142);
        @(posedge clk); #1;

        // back-to-back: next request presented in the DONE cycle
        start_op(3'd5, 32'd100, 32'd7);
        wait_done(0, n, st);
        chk("b2b1_lat", 32'(n), 32'd32);
        chk("b2b1_res", result, 32'd14);
        start_op(3'd7, 32'd100, 32'd7);
        chk("b2b_gap_done", {31'd0, done}, 32'd0);
        chk("b2b_gap_busy", {31'd0, busy}, 32'd1);
        wait_done(1, n, st);
        chk("b2b2_lat", 32'(n), 32'd33);
        chk("b2b2_res", result, 32'd2);
        chk("b2b2_hold", {31'd0, st}, 32'd1);
        @(posedge clk); #1;

        // asynchronous reset mid-BUSY
        start_op(3'd4, 32'd5000, 32'd3);
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_ready", {31'd0, ready}, 32'd1);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_done", {31'd0, done}, 32'd0);
        chk("arst_result", result, 32'd0);
        last_res = 32'd0;
        @(negedge clk); rst_n = 1'b1;
        do_op("post_rst", 3'd6, 32'd5000, 32'd3);

        // random operations against the reference model
        for (int i = 0; i < 40; i++) begin
            logic [2:0] f;
            f = 3'($urandom_range(0, 7));
            do_op("rand", f, pick(), pick());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
